// File: rtl/fb_sprite_blitter.sv
// Copies one 16x16 sprite from a synchronous ROM into the 240x160 framebuffer, skipping key-colour and off-screen pixels.
// Defining FB_BLIT_FLIP_EN adds the flip_x input for horizontally mirrored blits.
module fb_sprite_blitter #(
  parameter int          SPR_W     = 16,
  parameter int          SPR_H     = 16,
  parameter int          FB_W      = 240,
  parameter int          FB_H      = 160,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [3:0]  spr_idx,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
`ifdef FB_BLIT_FLIP_EN
  input  logic        flip_x,
`endif
  output logic        busy,
  output logic        done,
  output logic [11:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [18:0] FBwrite_address,
  output logic [23:0] FBdata_In,
  output logic        FBwe
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [3:0]    sidx;
  logic [9:0]    sx, sy;
  logic          flip, flip_in;
  logic [RW-1:0] row, nrow;
  logic [CW-1:0] col, ncol;
  logic          last;
  logic [10:0]   px, py;
  logic          inb;
  logic [18:0]   addr;
  logic          pvld, pinb;
  logic [18:0]   paddr, hold_addr;
  logic [23:0]   hold_data;

`ifdef FB_BLIT_FLIP_EN
  assign flip_in = flip_x;
`else
  assign flip_in = 1'b0;
`endif

  function automatic logic [CW-1:0] rcol(input logic f, input logic [CW-1:0] c);
    return f ? ~c : c;
  endfunction

  assign last = (row == RW'(SPR_H - 1)) && (col == CW'(SPR_W - 1));
  assign ncol = col + 1'b1;
  assign nrow = (col == CW'(SPR_W - 1)) ? row + 1'b1 : row;

  // Screen coordinates of the pixel being issued, 11-bit two's complement.
  assign px   = {sx[9], sx} + 11'(col);
  assign py   = {sy[9], sy} + 11'(row);
  assign inb  = !px[10] && !py[10] && (px < 11'(FB_W)) && (py < 11'(FB_H));
  assign addr = 19'(py) * 19'(FB_W) + 19'(px);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      sidx      <= '0;
      sx        <= '0;
      sy        <= '0;
      flip      <= 1'b0;
      row       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_addr  <= '0;
      pvld      <= 1'b0;
      pinb      <= 1'b0;
      paddr     <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sidx     <= spr_idx;
            sx       <= pos_x;
            sy       <= pos_y;
            flip     <= flip_in;
            row      <= '0;
            col      <= '0;
            rom_addr <= {spr_idx, {RW{1'b0}}, rcol(flip_in, '0)};
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // Tag travels alongside the ROM's own output register.
          pvld  <= 1'b1;
          pinb  <= inb;
          paddr <= addr;
          if (last) begin
            state <= DRAIN;
          end else begin
            row      <= nrow;
            col      <= ncol;
            rom_addr <= {sidx, nrow, rcol(flip, ncol)};
          end
        end
        DRAIN: begin
          pvld  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (FBwe) begin
        hold_addr <= paddr;
        hold_data <= rom_data;
      end
    end
  end

  // The ROM output register is the data stage, so the write port is a mux of registered values.
  assign FBwe            = pvld && pinb && (rom_data != KEY_COLOR);
  assign FBwrite_address = FBwe ? paddr : hold_addr;
  assign FBdata_In       = FBwe ? rom_data : hold_data;

endmodule

// File: tb/tb_fb_sprite_blitter.sv
// Self-checking bench for fb_sprite_blitter: randomized blits against a pixel-level reference model.
module tb_fb_sprite_blitter;

  localparam int          NMAX = 540;
  localparam logic [23:0] KEY  = 24'hFF00FF;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  spr_idx = '0;
  logic [9:0]  pos_x = '0, pos_y = '0;
  logic        flip_x = 1'b0;
  logic        busy, done, FBwe;
  logic [11:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic [18:0] FBwrite_address;
  logic [23:0] FBdata_In;

  logic [23:0] rom [4096];
  // {busy, done, FBwe, FBwrite_address[18:0], FBdata_In[23:0], rom_addr[11:0]}
  logic [57:0] obs  [NMAX+1];
  logic [57:0] expv [NMAX+1];

  int nb;
  int b_base [2], b_idx [2], b_px [2], b_py [2], b_flip [2];
  logic [18:0] m_addr = '0;
  logic [23:0] m_data = '0;
  logic [11:0] m_raddr = '0;

  int checks = 0;
  int errors = 0;

  fb_sprite_blitter dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .start(start),
    .spr_idx(spr_idx),
    .pos_x(pos_x),
    .pos_y(pos_y),
`ifdef FB_BLIT_FLIP_EN
    .flip_x(flip_x),
`endif
    .busy(busy),
    .done(done),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .FBwrite_address(FBwrite_address),
    .FBdata_In(FBdata_In),
    .FBwe(FBwe)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic fill_counting();
    for (int a = 0; a < 4096; a++) rom[a] = 24'(a);
  endtask

  task automatic fill_random(input int key_pct);
    logic [23:0] v;
    for (int a = 0; a < 4096; a++) begin
      v = 24'($urandom);
      if (v == KEY || $urandom_range(0, 99) < key_pct) v = (key_pct > 0) ? KEY : 24'h000001;
      rom[a] = v;
    end
  endtask

  task automatic set_blit(input int s, input int base, input int idx, input int px, input int py, input int fl);
    b_base[s] = base; b_idx[s] = idx; b_px[s] = px; b_py[s] = py; b_flip[s] = fl;
  endtask

  // Timeline model: cycle 1 = first cycle after the accepting edge.
  task automatic build_model(input int len);
    int rel, k, r, c, rc, x, y;
    logic [23:0] d;
    logic bz, dn, we;
    for (int n = 1; n <= len; n++) begin
      bz = 0; dn = 0; we = 0;
      for (int b = 0; b < nb; b++) begin
        rel = n - b_base[b];
        if (rel >= 1 && rel <= 257) bz = 1;
        if (rel == 258) dn = 1;
        if (rel >= 1 && rel <= 256) begin
          r = (rel - 1) / 16; c = (rel - 1) % 16;
          rc = (b_flip[b] != 0) ? 15 - c : c;
          m_raddr = 12'(b_idx[b] * 256 + r * 16 + rc);
        end
        if (rel >= 2 && rel <= 257) begin
          k = rel - 2; r = k / 16; c = k % 16;
          rc = (b_flip[b] != 0) ? 15 - c : c;
          d = rom[b_idx[b] * 256 + r * 16 + rc];
          x = b_px[b] + c; y = b_py[b] + r;
          if (x >= 0 && x < 240 && y >= 0 && y < 160 && d != KEY) begin
            we = 1; m_addr = 19'(y * 240 + x); m_data = d;
          end
        end
      end
      expv[n] = {bz, dn, we, m_addr, m_data, m_raddr};
    end
  endtask

  task automatic run_blit(input int len, input int idx, input int px, input int py, input logic fl, input int again_at);
    @(negedge Clk);
    spr_idx = 4'(idx); pos_x = 10'(px); pos_y = 10'(py); flip_x = fl; start = 1'b1;
    @(posedge Clk);
    for (int n = 1; n <= len; n++) begin
      @(negedge Clk);
      obs[n] = {busy, done, FBwe, FBwrite_address, FBdata_In, rom_addr};
      start = (n == again_at);
    end
    start = 1'b0;
  endtask

  function automatic int count_writes(input int len);
    int w = 0;
    for (int n = 1; n <= len; n++) if (obs[n][55]) w++;
    return w;
  endfunction

  task automatic test_reset();
    logic [57:0] v;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      start = ~start;
      #1;
      v = {busy, done, FBwe, FBwrite_address, FBdata_In, rom_addr};
      checks++;
      if (v !== 58'd0) begin
        errors++; $display("FAIL reset_outputs got %h expected 0", v);
      end
    end
    @(negedge Clk);
    start = 1'b0; Reset_n = 1'b1;
  endtask

  task automatic test_full_copy();
    fill_counting();
    nb = 1; set_blit(0, 0, 0, 0, 0, 0);
    build_model(262);
    run_blit(262, 0, 0, 0, 1'b0, 0);
    for (int n = 1; n <= 262; n++) begin
      checks++;
      if (obs[n] !== expv[n]) begin
        errors++; $display("FAIL full_copy cycle %0d got %h expected %h", n, obs[n], expv[n]);
      end
    end
    checks++;
    if (obs[2][55:12] !== {1'b1, 19'd0, 24'd0}) begin
      errors++; $display("FAIL full_first_write got %h expected %h", obs[2][55:12], {1'b1, 19'd0, 24'd0});
    end
    checks++;
    if (obs[257][55:12] !== {1'b1, 19'd3615, 24'd255}) begin
      errors++; $display("FAIL full_last_write got %h expected %h", obs[257][55:12], {1'b1, 19'd3615, 24'd255});
    end
    checks++;
    if (count_writes(262) != 256) begin
      errors++; $display("FAIL full_write_count got %0d expected 256", count_writes(262));
    end
    checks++;
    if (obs[258][57:56] !== 2'b01) begin
      errors++; $display("FAIL full_done_258 got busy,done=%b expected 01", obs[258][57:56]);
    end
  endtask

  task automatic test_transparency();
    int idx = $urandom_range(0, 15);
    for (int a = 0; a < 4096; a++) rom[a] = KEY;
    rom[idx * 256 + 5 * 16 + 3] = 24'h123456;
    nb = 1; set_blit(0, 0, idx, 10, 20, 0);
    build_model(262);
    run_blit(262, idx, 10, 20, 1'b0, 0);
    for (int n = 1; n <= 262; n++) begin
      checks++;
      if (obs[n] !== expv[n]) begin
        errors++; $display("FAIL transparency cycle %0d got %h expected %h", n, obs[n], expv[n]);
      end
    end
    checks++;
    if (count_writes(262) != 1) begin
      errors++; $display("FAIL transp_count got %0d expected 1", count_writes(262));
    end
    checks++;
    if (obs[2 + 5 * 16 + 3][55:12] !== {1'b1, 19'd6013, 24'h123456}) begin
      errors++; $display("FAIL transp_write got %h expected %h", obs[85][55:12], {1'b1, 19'd6013, 24'h123456});
    end
  endtask

  task automatic test_clipping();
    fill_random(0);
    nb = 1; set_blit(0, 0, 3, -8, 150, 0);
    build_model(262);
    run_blit(262, 3, -8, 150, 1'b0, 0);
    for (int n = 1; n <= 262; n++) begin
      checks++;
      if (obs[n] !== expv[n]) begin
        errors++; $display("FAIL clipping cycle %0d got %h expected %h", n, obs[n], expv[n]);
      end
    end
    checks++;
    if (count_writes(262) != 80) begin
      errors++; $display("FAIL clip_count got %0d expected 80", count_writes(262));
    end
    checks++;
    if (obs[10][55:36] !== {1'b1, 19'd36000}) begin
      errors++; $display("FAIL clip_first got %h expected %h", obs[10][55:36], {1'b1, 19'd36000});
    end
    checks++;
    if (obs[258][56] !== 1'b1) begin
      errors++; $display("FAIL clip_done got %b expected 1", obs[258][56]);
    end
  endtask

  task automatic test_random();
    int idx, x, y;
    for (int it = 0; it < 4; it++) begin
      fill_random(20);
      idx = $urandom_range(0, 15);
      x = $urandom_range(0, 270) - 20;
      y = $urandom_range(0, 190) - 20;
      nb = 1; set_blit(0, 0, idx, x, y, 0);
      build_model(262);
      run_blit(262, idx, x, y, 1'b0, 0);
      for (int n = 1; n <= 262; n++) begin
        checks++;
        if (obs[n] !== expv[n]) begin
          errors++; $display("FAIL random%0d cycle %0d got %h expected %h", it, n, obs[n], expv[n]);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    fill_random(10);
    nb = 1; set_blit(0, 0, 7, 30, 40, 0);
    build_model(262);
    run_blit(262, 7, 30, 40, 1'b0, 50);
    for (int n = 1; n <= 262; n++) begin
      checks++;
      if (obs[n] !== expv[n]) begin
        errors++; $display("FAIL busy_ignore cycle %0d got %h expected %h", n, obs[n], expv[n]);
      end
    end
    checks++;
    if (obs[259][57] !== 1'b0 || obs[262][57] !== 1'b0) begin
      errors++; $display("FAIL busy_requeue got busy=%b/%b expected 0/0", obs[259][57], obs[262][57]);
    end
  endtask

  task automatic test_reset_mid_blit();
    int bad = 0;
    fill_counting();
    @(negedge Clk);
    spr_idx = 4'd0; pos_x = '0; pos_y = '0; flip_x = 1'b0; start = 1'b1;
    @(posedge Clk);
    for (int n = 1; n <= 100; n++) begin
      @(negedge Clk);
      start = 1'b0;
    end
    checks++;
    if (FBwe !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset got we,busy=%b%b expected 11", FBwe, busy);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({FBwe, busy, done} !== 3'b000) begin
      errors++; $display("FAIL async_reset got we,busy,done=%b%b%b expected 000", FBwe, busy, done);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    m_addr = '0; m_data = '0; m_raddr = '0;
    repeat (300) begin
      @(negedge Clk);
      if (done || busy || FBwe) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL post_reset_activity got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int idx = $urandom_range(0, 15);
    fill_random(15);
    nb = 2; set_blit(0, 0, idx, 100, 50, 0); set_blit(1, 258, idx, 100, 50, 0);
    build_model(520);
    run_blit(520, idx, 100, 50, 1'b0, 258);
    for (int n = 1; n <= 520; n++) begin
      checks++;
      if (obs[n] !== expv[n]) begin
        errors++; $display("FAIL back_to_back cycle %0d got %h expected %h", n, obs[n], expv[n]);
      end
    end
    checks++;
    if (obs[259][57:56] !== 2'b10) begin
      errors++; $display("FAIL b2b_restart got busy,done=%b expected 10", obs[259][57:56]);
    end
  endtask

`ifdef FB_BLIT_FLIP_EN
  task automatic test_flip();
    fill_counting();
    nb = 1; set_blit(0, 0, 0, 0, 0, 1);
    build_model(262);
    run_blit(262, 0, 0, 0, 1'b1, 0);
    for (int n = 1; n <= 262; n++) begin
      checks++;
      if (obs[n] !== expv[n]) begin
        errors++; $display("FAIL flip cycle %0d got %h expected %h", n, obs[n], expv[n]);
      end
    end
    checks++;
    if (obs[2][54:12] !== {19'd0, 24'd15}) begin
      errors++; $display("FAIL flip_addr0 got %h expected %h", obs[2][54:12], {19'd0, 24'd15});
    end
    checks++;
    if (obs[17][54:12] !== {19'd15, 24'd0}) begin
      errors++; $display("FAIL flip_addr15 got %h expected %h", obs[17][54:12], {19'd15, 24'd0});
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = '0;
    test_reset();
    test_full_copy();
    test_transparency();
    test_clipping();
    test_random();
    test_busy_ignore();
    test_reset_mid_blit();
    test_back_to_back();
`ifdef FB_BLIT_FLIP_EN
    test_flip();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
